chan_fifo_port: RTL and testbench
=================================

CHAN_FIFO_PORT -- requirements
Module: chan_fifo_port

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2, legal range 1..7.
REQ-002 SHALL have parameter DATA_CHAN, default 7'd0, channel carrying FIFO data.
REQ-003 SHALL have parameter STATUS_CHAN, default 7'd1, channel carrying control/status; must differ from DATA_CHAN.
REQ-004 SHALL have port clk_in  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset_in  input  1  synchronous, active-low reset.
REQ-006 SHALL have port chanAddr_in  input  7  channel selected by host, sampled every cycle.
REQ-007 SHALL have ports h2fData_in  input  8, h2fValid_in  input  1, h2fReady_out  output  1  host-to-FPGA byte pipe.
REQ-008 SHALL have ports f2hData_out  output  8, f2hValid_out  output  1, f2hReady_in  input  1  FPGA-to-host byte pipe.
REQ-009 SHALL have ports appRxData_out  output  8, appRxValid_out  output  1, appRxReady_in  input  1  host bytes delivered to application.
REQ-010 SHALL have ports appTxData_in  input  8, appTxValid_in  input  1, appTxReady_out  output  1  application bytes queued for host.

Function
REQ-011 SHALL contain RX FIFO (host->app) and TX FIFO (app->host), each first-word-fall-through, DEPTH_LOG2+1-bit occupancy count.
REQ-012 SHALL transfer on any pipe only in a cycle where its valid and ready are both 1.
REQ-013 chanAddr_in==DATA_CHAN: h2fReady_out = !rxFull; accepted h2f byte pushed into RX FIFO.
REQ-014 chanAddr_in==DATA_CHAN: f2hValid_out = !txEmpty, f2hData_out = TX head; transfer pops TX FIFO.
REQ-015 chanAddr_in==STATUS_CHAN write: h2fReady_out=1; accepted byte bit0=1 flushes RX FIFO, bit1=1 flushes TX FIFO, bits7:2 ignored.
REQ-016 chanAddr_in==STATUS_CHAN read: f2hValid_out=1, f2hData_out = {rxFull, rxEmpty, txFull, txEmpty, 4'b0} when DEPTH_LOG2<=3 else same upper nibble with low nibble = txCount[3:0] saturated to 4'hF.
REQ-017 Any other channel: h2fReady_out=1 with byte discarded; f2hValid_out=1, f2hData_out=8'h00; FIFOs untouched.
REQ-018 appRxValid_out = !rxEmpty, appRxData_out = RX head; appTxReady_out = !txFull.
REQ-019 Latency: byte pushed in cycle N SHALL appear at FIFO output in cycle N+1; pop in cycle N exposes next entry in cycle N+1.
REQ-020 Ready SHALL depend only on registered full state; no same-cycle pass-through when full or empty.
REQ-021 Simultaneous push and pop on a non-empty, non-full FIFO SHALL leave count unchanged and preserve order.
REQ-022 Pointers SHALL wrap modulo depth; full = count==depth, empty = count==0.
REQ-023 Flush SHALL take effect next cycle (count=0, pointers=0) and SHALL win over any push/pop to the same FIFO in the flush cycle.
REQ-024 Change of chanAddr_in between transfers SHALL NOT affect FIFO contents.

Reset
REQ-025 While reset_in==0 at a clock edge: both FIFOs emptied, pointers/counts=0.
REQ-026 While reset_in==0: h2fReady_out=0, f2hValid_out=0, appRxValid_out=0, appTxReady_out=0, f2hData_out=8'h00, appRxData_out=8'h00.
REQ-027 Reset asserted mid-transfer SHALL discard all buffered bytes; first cycle after release both FIFOs empty, appTxReady_out=1.

Structure
REQ-028 Shared package SHALL hold default DATA_CHAN/STATUS_CHAN values and status-byte bit positions (RX_FULL=7, RX_EMPTY=6, TX_FULL=5, TX_EMPTY=4) and flush bit positions.
REQ-029 SHALL instantiate sub-module chan_fifo (parameterised sync FWFT FIFO with push/pop/flush/count) twice.

Verification
REQ-030 Reset then host writes 3 bytes 0x11,0x22,0x33 on chan 0 -> appRxData_out delivers 0x11,0x22,0x33 in order, first appRxValid_out 1 cycle after first push.
REQ-031 Host writes 17 bytes on chan 0 with appRxReady_in=0, DEPTH_LOG2=4 -> 16 accepted, h2fReady_out=0 on 17th; status read returns bit7=1.
REQ-032 App pushes 0xA5 with empty TX, host reads chan 0 -> f2hValid_out=0 at push cycle, f2hData_out=0xA5 with f2hValid_out=1 next cycle.
REQ-033 TX holds 5 bytes, host writes 0x02 to chan 1 -> next cycle txEmpty=1, status read returns 8'h50; RX untouched.
REQ-034 Continuous push+pop on RX at half-full for 40 cycles -> count constant, data order intact across pointer wrap.
REQ-035 reset_in driven low during a 10-byte transfer with 6 buffered -> outputs per REQ-026, after release status read = 8'h50.

Source files
------------

// File: rtl/chan_fifo_port_pkg.sv
// Shared definitions for the channel FIFO port: default channel numbers,
// status-byte layout and flush-command bit positions.
package chan_fifo_port_pkg;

    localparam logic [6:0] DEFAULT_DATA_CHAN   = 7'd0;
    localparam logic [6:0] DEFAULT_STATUS_CHAN = 7'd1;

    localparam int STAT_RX_FULL_BIT  = 7;
    localparam int STAT_RX_EMPTY_BIT = 6;
    localparam int STAT_TX_FULL_BIT  = 5;
    localparam int STAT_TX_EMPTY_BIT = 4;

    localparam int FLUSH_RX_BIT = 0;
    localparam int FLUSH_TX_BIT = 1;

    typedef enum logic [1:0] {
        SEL_DATA,
        SEL_STATUS,
        SEL_OTHER
    } chan_sel_e;

    function automatic logic [7:0] status_byte(
        input logic       rx_full,
        input logic       rx_empty,
        input logic       tx_full,
        input logic       tx_empty,
        input logic [3:0] level
    );
        logic [7:0] s;
        s                    = {4'h0, level};
        s[STAT_RX_FULL_BIT]  = rx_full;
        s[STAT_RX_EMPTY_BIT] = rx_empty;
        s[STAT_TX_FULL_BIT]  = tx_full;
        s[STAT_TX_EMPTY_BIT] = tx_empty;
        return s;
    endfunction

    // Occupancy reported in a nibble; anything above 15 reads as 15.
    function automatic logic [3:0] sat_level(input logic [7:0] count);
        return (count > 8'd15) ? 4'hF : count[3:0];
    endfunction

endpackage

// File: rtl/chan_fifo.sv
// Synchronous first-word-fall-through FIFO with push, pop, flush and an
// occupancy count one bit wider than the pointers.
module chan_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  full;
    logic                  empty;
    logic                  push_ok;
    logic                  pop_ok;

    // Count never exceeds DEPTH, so its MSB alone marks the full state.
    assign full    = count[DEPTH_LOG2];
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; pointers and count decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/chan_fifo_port.sv
// Channel-addressed byte port: one channel streams through RX/TX FIFOs,
// one carries flush commands and a status byte, all others are inert.
module chan_fifo_port
    import chan_fifo_port_pkg::*;
#(
    parameter int         DEPTH_LOG2  = 4,
    parameter logic [6:0] DATA_CHAN   = DEFAULT_DATA_CHAN,
    parameter logic [6:0] STATUS_CHAN = DEFAULT_STATUS_CHAN
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic [6:0] chanAddr_in,
    input  logic [7:0] h2fData_in,
    input  logic       h2fValid_in,
    output logic       h2fReady_out,
    output logic [7:0] f2hData_out,
    output logic       f2hValid_out,
    input  logic       f2hReady_in,
    output logic [7:0] appRxData_out,
    output logic       appRxValid_out,
    input  logic       appRxReady_in,
    input  logic [7:0] appTxData_in,
    input  logic       appTxValid_in,
    output logic       appTxReady_out
);

    chan_sel_e             sel;
    logic [DEPTH_LOG2:0]   rx_count;
    logic [DEPTH_LOG2:0]   tx_count;
    logic [7:0]            rx_head;
    logic [7:0]            tx_head;
    logic                  rx_full;
    logic                  rx_empty;
    logic                  tx_full;
    logic                  tx_empty;
    logic [3:0]            tx_level;
    logic [7:0]            status;
    logic                  h2f_fire;
    logic                  status_wr;
    logic                  rx_push;
    logic                  rx_pop;
    logic                  rx_flush;
    logic                  tx_push;
    logic                  tx_pop;
    logic                  tx_flush;

    assign rx_full  = rx_count[DEPTH_LOG2];
    assign rx_empty = (rx_count == '0);
    assign tx_full  = tx_count[DEPTH_LOG2];
    assign tx_empty = (tx_count == '0);

    // Small FIFOs have no meaningful level to report, so the low nibble stays zero.
    assign tx_level = (DEPTH_LOG2 <= 3) ? 4'h0 : sat_level(8'(tx_count));
    assign status   = status_byte(rx_full, rx_empty, tx_full, tx_empty, tx_level);

    always_comb begin
        sel = SEL_OTHER;
        if (chanAddr_in == DATA_CHAN)        sel = SEL_DATA;
        else if (chanAddr_in == STATUS_CHAN) sel = SEL_STATUS;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        h2fReady_out = 1'b0;
        f2hValid_out = 1'b0;
        f2hData_out  = 8'h00;
        if (reset_in) begin
            case (sel)
                SEL_DATA: begin
                    h2fReady_out = !rx_full;
                    f2hValid_out = !tx_empty;
                    f2hData_out  = tx_head;
                end
                SEL_STATUS: begin
                    h2fReady_out = 1'b1;
                    f2hValid_out = 1'b1;
                    f2hData_out  = status;
                end
                default: begin
                    h2fReady_out = 1'b1;
                    f2hValid_out = 1'b1;
                end
            endcase
        end
    end

    assign appRxValid_out = reset_in && !rx_empty;
    assign appRxData_out  = reset_in ? rx_head : 8'h00;
    assign appTxReady_out = reset_in && !tx_full;

    assign h2f_fire  = h2fValid_in && h2fReady_out;
    assign rx_push   = h2f_fire && (sel == SEL_DATA);
    assign status_wr = h2f_fire && (sel == SEL_STATUS);
    assign rx_flush  = status_wr && h2fData_in[FLUSH_RX_BIT];
    assign tx_flush  = status_wr && h2fData_in[FLUSH_TX_BIT];
    assign rx_pop    = appRxValid_out && appRxReady_in;
    assign tx_push   = appTxValid_in && appTxReady_out;
    assign tx_pop    = f2hValid_out && f2hReady_in && (sel == SEL_DATA);

    chan_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (8)
    ) u_rx_fifo (
        .clk       (clk_in),
        .rst_n     (reset_in),
        .push      (rx_push),
        .push_data (h2fData_in),
        .pop       (rx_pop),
        .flush     (rx_flush),
        .head      (rx_head),
        .count     (rx_count)
    );

    chan_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (8)
    ) u_tx_fifo (
        .clk       (clk_in),
        .rst_n     (reset_in),
        .push      (tx_push),
        .push_data (appTxData_in),
        .pop       (tx_pop),
        .flush     (tx_flush),
        .head      (tx_head),
        .count     (tx_count)
    );

endmodule

// File: tb/tb_chan_fifo_port.sv
// Self-checking bench for chan_fifo_port: a directed vector table for the
// basic paths, then hand sequences for fill, wrap, flush and reset corners.
module tb_chan_fifo_port;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic [6:0] chanAddr_in;
    logic [7:0] h2fData_in;
    logic       h2fValid_in;
    logic       h2fReady_out;
    logic [7:0] f2hData_out;
    logic       f2hValid_out;
    logic       f2hReady_in;
    logic [7:0] appRxData_out;
    logic       appRxValid_out;
    logic       appRxReady_in;
    logic [7:0] appTxData_in;
    logic       appTxValid_in;
    logic       appTxReady_out;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk_in = ~clk_in;

    chan_fifo_port #(
        .DEPTH_LOG2  (4),
        .DATA_CHAN   (7'd0),
        .STATUS_CHAN (7'd1)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .chanAddr_in    (chanAddr_in),
        .h2fData_in     (h2fData_in),
        .h2fValid_in    (h2fValid_in),
        .h2fReady_out   (h2fReady_out),
        .f2hData_out    (f2hData_out),
        .f2hValid_out   (f2hValid_out),
        .f2hReady_in    (f2hReady_in),
        .appRxData_out  (appRxData_out),
        .appRxValid_out (appRxValid_out),
        .appRxReady_in  (appRxReady_in),
        .appTxData_in   (appTxData_in),
        .appTxValid_in  (appTxValid_in),
        .appTxReady_out (appTxReady_out)
    );

    typedef struct packed {
        logic       rst;
        logic [6:0] chan;
        logic [7:0] hd;
        logic       hv;
        logic       fr;
        logic       rr;
        logic [7:0] td;
        logic       tv;
        logic       e_h2f_ready;
        logic       e_f2h_valid;
        logic [7:0] e_f2h_data;
        logic       e_rx_valid;
        logic [7:0] e_rx_data;
        logic       e_tx_ready;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic rst, input logic [6:0] chan, input logic [7:0] hd,
        input logic hv, input logic fr, input logic rr,
        input logic [7:0] td, input logic tv,
        input logic eh, input logic efv, input logic [7:0] efd,
        input logic erv, input logic [7:0] erd, input logic etr
    );
        return '{rst, chan, hd, hv, fr, rr, td, tv, eh, efv, efd, erv, erd, etr};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        reset_in      = 1'b1;
        chanAddr_in   = 7'd0;
        h2fData_in    = 8'h00;
        h2fValid_in   = 1'b0;
        f2hReady_in   = 1'b0;
        appRxReady_in = 1'b0;
        appTxData_in  = 8'h00;
        appTxValid_in = 1'b0;
    endtask

    task automatic status_read(input string name, input logic [7:0] exp);
        chanAddr_in = 7'd1;
        h2fValid_in = 1'b0;
        f2hReady_in = 1'b1;
        #1;
        check({name, ".valid"}, 32'(f2hValid_out), 32'd1);
        check({name, ".byte"},  32'(f2hData_out),  32'(exp));
    endtask

    initial begin
        int         errs;
        int         accepted;
        logic [7:0] q [$];
        logic [7:0] nxt;

        //           rst chan hd    hv fr rr td    tv | eh efv efd   erv erd   etr
        vecs[0]  = mk(0, 0, 8'h77, 1, 1, 1, 8'h66, 1,   0, 0, 8'h00, 0, 8'h00, 0);
        vecs[1]  = mk(0, 0, 8'h77, 1, 1, 1, 8'h66, 1,   0, 0, 8'h00, 0, 8'h00, 0);
        vecs[2]  = mk(1, 0, 8'h11, 1, 0, 0, 8'h00, 0,   1, 0, 8'h00, 0, 8'h00, 1);
        vecs[3]  = mk(1, 0, 8'h22, 1, 0, 0, 8'h00, 0,   1, 0, 8'h00, 1, 8'h11, 1);
        vecs[4]  = mk(1, 0, 8'h33, 1, 0, 1, 8'h00, 0,   1, 0, 8'h00, 1, 8'h11, 1);
        vecs[5]  = mk(1, 0, 8'h00, 0, 0, 1, 8'h00, 0,   1, 0, 8'h00, 1, 8'h22, 1);
        vecs[6]  = mk(1, 0, 8'h00, 0, 0, 1, 8'h00, 0,   1, 0, 8'h00, 1, 8'h33, 1);
        vecs[7]  = mk(1, 0, 8'h00, 0, 0, 1, 8'h00, 0,   1, 0, 8'h00, 0, 8'h00, 1);
        vecs[8]  = mk(1, 0, 8'h00, 0, 1, 0, 8'hA5, 1,   1, 0, 8'h00, 0, 8'h00, 1);
        vecs[9]  = mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 0,   1, 1, 8'hA5, 0, 8'h00, 1);
        vecs[10] = mk(1, 1, 8'h00, 0, 0, 0, 8'h00, 0,   1, 1, 8'h41, 0, 8'h00, 1);
        vecs[11] = mk(1, 5, 8'hFF, 1, 1, 0, 8'h00, 0,   1, 1, 8'h00, 0, 8'h00, 1);
        vecs[12] = mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 0,   1, 1, 8'hA5, 0, 8'h00, 1);
        vecs[13] = mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 0,   1, 0, 8'h00, 0, 8'h00, 1);
        vecs[14] = mk(1, 1, 8'h00, 0, 0, 0, 8'h00, 0,   1, 1, 8'h50, 0, 8'h00, 1);

        idle();
        step();
        for (int i = 0; i < NVEC; i++) begin
            reset_in      = vecs[i].rst;
            chanAddr_in   = vecs[i].chan;
            h2fData_in    = vecs[i].hd;
            h2fValid_in   = vecs[i].hv;
            f2hReady_in   = vecs[i].fr;
            appRxReady_in = vecs[i].rr;
            appTxData_in  = vecs[i].td;
            appTxValid_in = vecs[i].tv;
            #1;
            check($sformatf("v%0d.h2f_ready", i), 32'(h2fReady_out), 32'(vecs[i].e_h2f_ready));
            check($sformatf("v%0d.f2h_valid", i), 32'(f2hValid_out), 32'(vecs[i].e_f2h_valid));
            check($sformatf("v%0d.rx_valid", i),  32'(appRxValid_out), 32'(vecs[i].e_rx_valid));
            check($sformatf("v%0d.tx_ready", i),  32'(appTxReady_out), 32'(vecs[i].e_tx_ready));
            if (vecs[i].e_f2h_valid || !vecs[i].rst)
                check($sformatf("v%0d.f2h_data", i), 32'(f2hData_out), 32'(vecs[i].e_f2h_data));
            if (vecs[i].e_rx_valid || !vecs[i].rst)
                check($sformatf("v%0d.rx_data", i), 32'(appRxData_out), 32'(vecs[i].e_rx_data));
            step();
        end

        // TX flush leaves RX alone and beats a same-cycle app push.
        idle();
        h2fValid_in = 1'b1; h2fData_in = 8'h5A;
        step();
        h2fValid_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            appTxValid_in = 1'b1; appTxData_in = 8'hC0 + 8'(i);
            step();
        end
        appTxValid_in = 1'b0;
        status_read("st_tx5", 8'h05);
        step();
        f2hReady_in = 1'b0;
        h2fValid_in = 1'b1; h2fData_in = 8'hFE;
        appTxValid_in = 1'b1; appTxData_in = 8'hEE;
        #1;
        check("flush_tx.h2f_ready", 32'(h2fReady_out), 32'd1);
        step();
        idle();
        status_read("st_after_txflush", 8'h10);
        check("rx_kept.valid", 32'(appRxValid_out), 32'd1);
        check("rx_kept.data",  32'(appRxData_out),  32'h5A);
        appRxReady_in = 1'b1;
        step();
        appRxReady_in = 1'b0;
        status_read("st_empty", 8'h50);
        step();

        // RX flush beats a same-cycle app pop.
        idle();
        for (int i = 0; i < 2; i++) begin
            h2fValid_in = 1'b1; h2fData_in = 8'h01 + 8'(i);
            step();
        end
        chanAddr_in = 7'd1; h2fData_in = 8'h01; appRxReady_in = 1'b1;
        step();
        idle();
        #1;
        check("flush_rx.rx_valid", 32'(appRxValid_out), 32'd0);
        step();

        // TX fill to full: level saturates at F.
        accepted = 0;
        for (int i = 0; i < 16; i++) begin
            appTxValid_in = 1'b1; appTxData_in = 8'h80 + 8'(i);
            #1;
            if (appTxReady_out) accepted++;
            step();
        end
        appTxValid_in = 1'b0;
        check("tx_fill.accepted", 32'(accepted), 32'd16);
        #1;
        check("tx_full.ready", 32'(appTxReady_out), 32'd0);
        status_read("st_tx_full", 8'h6F);
        chanAddr_in = 7'd0;
        f2hReady_in = 1'b0;
        #1;
        check("tx_full.head", 32'(f2hData_out), 32'h80);
        chanAddr_in = 7'd1; h2fValid_in = 1'b1; h2fData_in = 8'h02;
        step();
        idle();
        status_read("st_after_tx_full_flush", 8'h50);
        step();

        // Host overruns RX: 16 accepted, 17th refused, order preserved.
        idle();
        accepted = 0;
        for (int i = 0; i < 16; i++) begin
            h2fValid_in = 1'b1; h2fData_in = 8'(i);
            #1;
            if (h2fReady_out) accepted++;
            step();
        end
        h2fData_in = 8'd16;
        #1;
        check("rx_fill.accepted", 32'(accepted), 32'd16);
        check("rx_fill.ready17", 32'(h2fReady_out), 32'd0);
        step();
        status_read("st_rx_full", 8'h90);
        step();
        idle();
        appRxReady_in = 1'b1;
        errs = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (!appRxValid_out || appRxData_out !== 8'(i)) errs++;
            step();
        end
        check("rx_drain.errors", 32'(errs), 32'd0);
        check("rx_drain.empty", 32'(appRxValid_out), 32'd0);

        // Half-full streaming across pointer wrap.
        idle();
        q = {};
        for (int i = 0; i < 8; i++) begin
            h2fValid_in = 1'b1; h2fData_in = 8'h40 + 8'(i);
            q.push_back(8'h40 + 8'(i));
            step();
        end
        errs = 0;
        appRxReady_in = 1'b1;
        for (int k = 0; k < 40; k++) begin
            nxt = 8'h48 + 8'(k);
            h2fData_in = nxt;
            #1;
            if (!h2fReady_out || !appRxValid_out || appRxData_out !== q[0]) errs++;
            void'(q.pop_front());
            q.push_back(nxt);
            step();
        end
        h2fValid_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (!appRxValid_out || appRxData_out !== q[0]) errs++;
            void'(q.pop_front());
            step();
        end
        #1;
        check("stream.errors", 32'(errs), 32'd0);
        check("stream.count8", 32'(appRxValid_out), 32'd0);

        // Reset mid-transfer with 6 bytes buffered.
        idle();
        for (int i = 0; i < 6; i++) begin
            h2fValid_in = 1'b1; h2fData_in = 8'hB0 + 8'(i);
            appTxValid_in = 1'b1; appTxData_in = 8'hD0 + 8'(i);
            step();
        end
        h2fData_in = 8'hB6;
        f2hReady_in = 1'b1;
        reset_in = 1'b0;
        #1;
        check("rst.h2f_ready", 32'(h2fReady_out), 32'd0);
        check("rst.f2h_valid", 32'(f2hValid_out), 32'd0);
        check("rst.f2h_data",  32'(f2hData_out),  32'd0);
        check("rst.rx_valid",  32'(appRxValid_out), 32'd0);
        check("rst.rx_data",   32'(appRxData_out),  32'd0);
        check("rst.tx_ready",  32'(appTxReady_out), 32'd0);
        step();
        h2fData_in = 8'hB7;
        step();
        idle();
        #1;
        check("rel.tx_ready", 32'(appTxReady_out), 32'd1);
        check("rel.rx_valid", 32'(appRxValid_out), 32'd0);
        status_read("st_after_reset", 8'h50);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
